// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction fetch front end. It issues word reads to a synchronous
// instruction ROM, decodes each returned word into MIPS-style fields and
// buffers the results in a small FIFO for the decode stage. A request is only
// issued when the queue has space for it and for any response already in
// flight, so the queue can never overflow. A redirect flushes the queue, drops
// the in-flight response and restarts fetch at the new word address.
//
// Optional feature (macro INSTQ_BYPASS_EN):
//   When the macro is defined and the queue is empty, a response is presented
//   on the head outputs in the cycle it arrives. If the consumer takes it, it
//   is never written into the queue. Without the macro, the head outputs only
//   show stored entries.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2)
//   MEM_BITS  instruction-memory word-address width
//   RESET_PC  fetch word address after reset
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   imem_req/imem_addr  ROM read request and word address
//   imem_data           ROM word, valid one cycle after imem_req
//   redirect/_pc        flush and restart fetch at redirect_pc
//   deq_ready           consumer accepts the head entry
//   deq_valid           head entry present
//   opcode..address     decoded fields of the head entry
//   pc                  word address the head entry was fetched from
//   pc_in_range         head pc lies inside the instruction memory
//   count               occupied queue entries
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MEM_BITS = 11,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [MEM_BITS-1:0]      imem_addr,
    input  logic [31:0]              imem_data,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output logic [11:0]              opcode,
    output logic [4:0]               rs,
    output logic [4:0]               rt,
    output logic [4:0]               rd,
    output logic [4:0]               shamt,
    output logic [15:0]              immediate,
    output logic [25:0]              address,
    output logic [31:0]              pc,
    output logic                     pc_in_range,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OCC_W  = CNT_W + 1;
    localparam int unsigned WORD_W = 32;

    // One past the last valid word address; 33 bits so it never overflows.
    localparam logic [WORD_W:0] MEM_SIZE = (WORD_W + 1)'(1) << MEM_BITS;

    typedef struct packed {
        logic [11:0] opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] immediate;
        logic [25:0] address;
    } dec_t;

    // R-type words carry the function code in the low opcode bits.
    function automatic dec_t decode(input logic [WORD_W-1:0] inst);
        dec_t d;
        if (inst[31:26] == 6'd0) begin
            d.opcode = {inst[31:26], inst[5:0]};
        end else begin
            d.opcode = {inst[31:26], 6'd0};
        end
        d.rs        = inst[25:21];
        d.rt        = inst[20:16];
        d.rd        = inst[15:11];
        d.shamt     = inst[10:6];
        d.immediate = inst[15:0];
        d.address   = inst[25:0];
        return d;
    endfunction

    // Fetch and queue state
    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] req_pc;
    logic              inflight;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  cnt;

    logic [WORD_W-1:0] inst_mem [DEPTH];
    logic [WORD_W-1:0] pc_mem   [DEPTH];

    // Control
    logic [OCC_W-1:0]  occupancy;
    logic              rsp_valid;
    logic              stored_valid;
    logic              bypass;
    logic              head_valid;
    logic              wr_en;
    logic              rd_en;

    // Head selection
    logic [WORD_W-1:0] head_inst;
    logic [WORD_W-1:0] head_pc;
    dec_t              dec;

    // Request credit, response handling and dequeue control.
    always_comb begin
        occupancy    = {1'b0, cnt} + {{CNT_W{1'b0}}, inflight};
        imem_req     = !redirect && (occupancy < OCC_W'(DEPTH));
        // A response returning during a redirect belongs to the old stream.
        rsp_valid    = inflight && !redirect;
        stored_valid = (cnt != '0);
`ifdef INSTQ_BYPASS_EN
        bypass       = rsp_valid && !stored_valid;
`else
        bypass       = 1'b0;
`endif
        head_valid   = stored_valid || bypass;
        deq_valid    = head_valid && !redirect;
        rd_en        = stored_valid && !redirect && deq_ready;
        // A bypassed word taken by the consumer is not stored.
        wr_en        = rsp_valid && !(bypass && deq_ready);
    end

    assign imem_addr = fetch_pc[MEM_BITS-1:0];
    assign count     = cnt;

    // Fetch PC, in-flight tracking and queue pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
        end else begin
            if (imem_req) begin
                fetch_pc <= fetch_pc + WORD_W'(1);
                req_pc   <= fetch_pc;
            end
            inflight <= imem_req;
            if (wr_en) begin
                tail <= tail + PTR_W'(1);
            end
            if (rd_en) begin
                head <= head + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Queue storage; contents are qualified by cnt, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_mem[tail] <= imem_data;
            pc_mem[tail]   <= req_pc;
        end
    end

    // Head entry decode; all fields read as zero when nothing is presented.
    always_comb begin
        head_inst   = inst_mem[head];
        head_pc     = pc_mem[head];
        if (bypass) begin
            head_inst = imem_data;
            head_pc   = req_pc;
        end
        dec         = '0;
        pc          = '0;
        pc_in_range = 1'b0;
        if (head_valid) begin
            dec         = decode(head_inst);
            pc          = head_pc;
            pc_in_range = ({1'b0, head_pc} < MEM_SIZE);
        end
        opcode    = dec.opcode;
        rs        = dec.rs;
        rt        = dec.rt;
        rd        = dec.rd;
        shamt     = dec.shamt;
        immediate = dec.immediate;
        address   = dec.address;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed bench for inst_fetch_queue (default build, DEPTH=4, MEM_BITS=11).
// A behavioural synchronous ROM answers fetches. The stimulus process walks a
// fixed cycle plan and pushes the entries it expects to be dequeued into a
// scoreboard; a monitor pops and compares on every dequeue handshake.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MEM_BITS = 11;
    localparam int unsigned MEM_SIZE = 2048;

    typedef struct packed {
        logic [31:0] pc;
        logic        in_range;
        logic [11:0] opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] immediate;
        logic [25:0] address;
    } entry_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                imem_req;
    logic [MEM_BITS-1:0] imem_addr;
    logic [31:0]         imem_data = 32'd0;
    logic                redirect;
    logic [31:0]         redirect_pc;
    logic                deq_ready;
    logic                deq_valid;
    logic [11:0]         opcode;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [4:0]          shamt;
    logic [15:0]         immediate;
    logic [25:0]         address;
    logic [31:0]         pc;
    logic                pc_in_range;
    logic [2:0]          count;

    int checks = 0;
    int errors = 0;

    entry_t sb[$];
    logic [31:0] rom [MEM_SIZE];

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .MEM_BITS (MEM_BITS),
        .RESET_PC (32'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq_ready   (deq_ready),
        .deq_valid   (deq_valid),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .immediate   (immediate),
        .address     (address),
        .pc          (pc),
        .pc_in_range (pc_in_range),
        .count       (count)
    );

    always #5 clk = ~clk;

    // ROM: word 0 = add $8,$9,$10; word 1 = lw $8,4($9); others addi $0,$0,i.
    initial begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            rom[i] = 32'h2000_0000 | 32'(i);
        end
        rom[0] = 32'h012A_4020;
        rom[1] = 32'h8D28_0004;
    end

    always @(posedge clk) begin
        if (imem_req) begin
            imem_data <= rom[imem_addr];
        end
    end

    // Expected head entry for a fetch from word address p.
    function automatic entry_t make_exp(input logic [31:0] p);
        entry_t e;
        logic [10:0] w;
        w          = p[10:0];
        e.pc       = p;
        e.in_range = (p < 32'd2048);
        if (w == 11'd0) begin
            e.opcode = 12'h020; e.rs = 5'd9; e.rt = 5'd10; e.rd = 5'd8; e.shamt = 5'd0;
            e.immediate = 16'h4020; e.address = 26'h12A_4020;
        end else if (w == 11'd1) begin
            e.opcode = 12'h8C0; e.rs = 5'd9; e.rt = 5'd8; e.rd = 5'd0; e.shamt = 5'd0;
            e.immediate = 16'h0004; e.address = 26'h128_0004;
        end else begin
            e.opcode = 12'h200; e.rs = 5'd0; e.rt = 5'd0; e.rd = 5'd0; e.shamt = w[10:6];
            e.immediate = {5'd0, w}; e.address = {15'd0, w};
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_range(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(make_exp(first + 32'(i)));
        end
    endtask

    // Monitor: every dequeue handshake must match the next expected entry.
    always @(negedge clk) begin
        entry_t act;
        entry_t exp;
        if (!rst && deq_valid && deq_ready) begin
            act = '{pc, pc_in_range, opcode, rs, rt, rd, shamt, immediate, address};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL deq_unexpected: got pc=0x%0h with nothing expected", pc);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL deq_entry: got %h expected %h", act, exp);
                end
            end
        end
    end

    // Stimulus: one iteration per cycle, inputs driven just after the edge.
    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        deq_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_deq_valid", 32'(deq_valid), 32'd0);
        chk("reset_fields_zero",
            32'(|{opcode, rs, rt, rd, shamt, immediate, address, pc, pc_in_range}), 32'd0);
        chk("reset_imem_addr", 32'(imem_addr), 32'd0);

        for (int cyc = 0; cyc < 56; cyc++) begin
            @(posedge clk);
            #1;
            rst       = (cyc == 43);
            redirect  = (cyc == 20) || (cyc == 25) || (cyc == 32) || (cyc == 33);
            case (cyc)
                20:      redirect_pc = 32'h0000_0100;
                25:      redirect_pc = 32'h0000_0040;
                32:      redirect_pc = 32'h0000_0200;
                33:      redirect_pc = 32'h0000_07FF;
                default: redirect_pc = 32'd0;
            endcase
            deq_ready = (cyc <= 5) || (cyc >= 10 && cyc <= 19) ||
                        (cyc >= 26 && cyc <= 41) || (cyc >= 44 && cyc <= 48);
            case (cyc)
                0:  push_range(32'd0, 14);
                26: push_range(32'h40, 4);
                34: push_range(32'h7FF, 6);
                44: push_range(32'd0, 3);
                default: ;
            endcase

            @(negedge clk);
            case (cyc)
                0: begin
                    chk("first_req", 32'(imem_req), 32'd1);
                    chk("first_addr", 32'(imem_addr), 32'd0);
                end
                1: begin
                    chk("latency_not_yet", 32'(deq_valid), 32'd0);
                    chk("second_addr", 32'(imem_addr), 32'd1);
                end
                2: chk("latency_two", 32'(deq_valid), 32'd1);
                9: begin
                    chk("full_count", 32'(count), 32'd4);
                    chk("full_no_req", 32'(imem_req), 32'd0);
                end
                25: begin
                    chk("redir_count_before", 32'(count), 32'd3);
                    chk("redir_deq_valid", 32'(deq_valid), 32'd0);
                    chk("redir_no_req", 32'(imem_req), 32'd0);
                end
                26: begin
                    chk("redir_count_after", 32'(count), 32'd0);
                    chk("redir_req", 32'(imem_req), 32'd1);
                    chk("redir_addr", 32'(imem_addr), 32'h40);
                end
                35: chk("addr_wrap", 32'(imem_addr), 32'd0);
                43: begin
                    chk("midrst_count", 32'(count), 32'd0);
                    chk("midrst_deq_valid", 32'(deq_valid), 32'd0);
                    chk("midrst_fields_zero",
                        32'(|{opcode, rs, rt, rd, shamt, immediate, address, pc, pc_in_range}),
                        32'd0);
                end
                44: chk("restart_addr", 32'(imem_addr), 32'd0);
                default: ;
            endcase
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 Parameter MEM_BITS, default 11, instruction-memory word-address width; MEM_SIZE = 2**MEM_BITS.
REQ-003 Parameter RESET_PC, default 0, fetch word address after reset.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 imem_req  out  1  read request to synchronous instruction ROM.
REQ-007 imem_addr  out  MEM_BITS  word address = fetch_pc[MEM_BITS-1:0].
REQ-008 imem_data  in  32  instruction word, valid exactly one cycle after imem_req.
REQ-009 redirect  in  1  flush queue and restart fetch (branch/mispredict).
REQ-010 redirect_pc  in  32  new fetch word address.
REQ-011 deq_ready  in  1  consumer accepts head entry.
REQ-012 deq_valid  out  1  head entry present.
REQ-013 opcode  out  12; rs, rt, rd, shamt  out  5 each; immediate  out  16; address  out  26; pc  out  32: decoded head fields.
REQ-014 pc_in_range  out  1  head pc < MEM_SIZE.
REQ-015 count  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-016 Decode: opcode = {inst[31:26], inst[5:0]} if inst[31:26]==0, else {inst[31:26], 6'd0}; rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], immediate=[15:0], address=[25:0].
REQ-017 imem_req = !redirect && (count + inflight) < DEPTH; inflight = imem_req registered one cycle.
REQ-018 Each cycle imem_req is high, fetch_pc increments by 1 (word step); 32-bit wrap, no saturation.
REQ-019 Response cycle (inflight=1): imem_data decoded and written at tail with the pc that issued it, unless discarded per REQ-022.
REQ-020 deq_valid = (count != 0) && !redirect; dequeue when deq_valid && deq_ready; head advances next edge.
REQ-021 Simultaneous write and dequeue: count unchanged, both pointers advance; credit rule (REQ-017) guarantees no overflow, no write when full.
REQ-022 redirect: next edge count=0, pointers reset, fetch_pc = redirect_pc; response arriving in the cycle after redirect is discarded; no request in redirect cycle.
REQ-023 Back-to-back redirects: last redirect_pc wins; each discards the in-flight response.
REQ-024 Out-of-range pc entries still enqueue; pc_in_range=0 flags them.
REQ-025 Steady state with deq_ready=1: one instruction per cycle, fetch-to-deq latency 2 cycles (without bypass).
REQ-026 Pointers wrap modulo DEPTH.

Reset
REQ-027 rst high: count=0, pointers=0, inflight=0, fetch_pc=RESET_PC, deq_valid=0; all decoded outputs 0 while empty.
REQ-028 Response in flight when rst asserts is discarded; first imem_req after rst deassert is at RESET_PC.

Configuration
REQ-029 Macro INSTQ_BYPASS_EN defined: when count==0, a non-discarded response drives outputs combinationally with deq_valid=1 in the response cycle; if deq_ready=1 it is consumed and not written, otherwise written normally; latency 1 cycle.
REQ-030 INSTQ_BYPASS_EN undefined: no bypass; deq_valid only reflects stored entries.

Verification
REQ-031 Reset, ROM[0]=0x012A4020 (add), deq_ready=1 -> opcode=0x020, rs=9, rt=10, rd=8, pc=0, pc_in_range=1, two cycles after first imem_req.
REQ-032 ROM[1]=0x8D280004 (lw) -> opcode=0x8C0, immediate=0x0004, address=0x1280004.
REQ-033 DEPTH=4, deq_ready=0 -> count saturates at 4, imem_req low; release deq_ready -> pcs 0,1,2,3,4... in order, none lost or duplicated.
REQ-034 Queue count=3, redirect=1, redirect_pc=0x40 -> deq_valid=0 that cycle, count=0 next, next imem_addr=0x40, stale response never dequeued.
REQ-035 redirect_pc=0x7FF -> entry pc=0x7FF pc_in_range=1; following entry pc=0x800 pc_in_range=0, imem_addr=0x000.
REQ-036 With INSTQ_BYPASS_EN, empty queue, deq_ready=1 -> deq_valid in response cycle, count stays 0.
